// File: rtl/fork_arbiter.sv
// Fork arbiter for the dining-philosopher table: latches hungry requests, grants
// fork pairs round-robin, and drives per-philosopher EAT and periodic TIMEOUT events.
module fork_arbiter #(
    parameter int N_PHILO  = 3,
    parameter int EVENT_W  = 2,
    parameter int TICK_DIV = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_PHILO-1:0]         hungry,
    input  logic [N_PHILO-1:0]         done,
    output logic [N_PHILO*EVENT_W-1:0] evt_out,
    output logic [N_PHILO-1:0]         eating,
    output logic [N_PHILO-1:0]         fork_busy
);

    localparam int PTR_W = (N_PHILO > 1) ? $clog2(N_PHILO) : 1;
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [CNT_W-1:0]   TICK_LAST   = CNT_W'(TICK_DIV - 1);
    localparam logic [EVENT_W-1:0] EVT_NONE    = EVENT_W'(0);
    localparam logic [EVENT_W-1:0] EVT_EAT     = EVENT_W'(1);
    localparam logic [EVENT_W-1:0] EVT_TIMEOUT = EVENT_W'(2);

    logic [N_PHILO-1:0]         pending_q, pending_d;
    logic [N_PHILO-1:0]         eating_q, eating_d;
    logic [N_PHILO-1:0]         fork_busy_q, fork_busy_d;
    logic [N_PHILO*EVENT_W-1:0] evt_out_q, evt_out_d;
    logic [PTR_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]           tick_q, tick_d;

    logic                       grant_found;
    logic [PTR_W-1:0]           grant_idx;
    logic [N_PHILO-1:0]         grant_vec;
    logic [N_PHILO-1:0]         release_vec;
    logic [N_PHILO-1:0]         release_forks;
    logic                       tick_fire;
    int                         scan_idx;
    int                         scan_nxt;

    // Grant search looks only at registered state, so same-edge frees and requests wait a cycle.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        scan_nxt    = 0;
        for (int off = 0; off < N_PHILO; off++) begin
            scan_idx = (int'(rr_ptr_q) + off) % N_PHILO;
            scan_nxt = (scan_idx + 1) % N_PHILO;
            if (!grant_found && pending_q[scan_idx] &&
                !fork_busy_q[scan_idx] && !fork_busy_q[scan_nxt]) begin
                grant_found = 1'b1;
                grant_idx   = PTR_W'(scan_idx);
            end
        end
    end

    always_comb begin
        grant_vec     = '0;
        release_vec   = done & eating_q;
        release_forks = '0;
        if (grant_found) begin
            grant_vec[grant_idx] = 1'b1;
        end
        for (int i = 0; i < N_PHILO; i++) begin
            if (release_vec[i]) begin
                release_forks[i]                 = 1'b1;
                release_forks[(i + 1) % N_PHILO] = 1'b1;
            end
        end
    end

    always_comb begin
        tick_fire   = (tick_q == TICK_LAST);
        tick_d      = tick_fire ? '0 : tick_q + 1'b1;
        pending_d   = (pending_q | (hungry & ~pending_q & ~eating_q)) & ~grant_vec;
        eating_d    = (eating_q & ~release_vec) | grant_vec;
        fork_busy_d = fork_busy_q & ~release_forks;
        rr_ptr_d    = rr_ptr_q;
        evt_out_d   = '0;
        if (grant_found) begin
            fork_busy_d[grant_idx]                              = 1'b1;
            fork_busy_d[(int'(grant_idx) + 1) % N_PHILO]        = 1'b1;
            rr_ptr_d                                            = PTR_W'((int'(grant_idx) + 1) % N_PHILO);
        end
        // EAT wins over a coincident TIMEOUT on the same lane; the TIMEOUT is simply lost.
        for (int i = 0; i < N_PHILO; i++) begin
            if (grant_vec[i]) begin
                evt_out_d[i*EVENT_W +: EVENT_W] = EVT_EAT;
            end else if (tick_fire) begin
                evt_out_d[i*EVENT_W +: EVENT_W] = EVT_TIMEOUT;
            end else begin
                evt_out_d[i*EVENT_W +: EVENT_W] = EVT_NONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q   <= '0;
            eating_q    <= '0;
            fork_busy_q <= '0;
            evt_out_q   <= '0;
            rr_ptr_q    <= '0;
            tick_q      <= '0;
        end else begin
            pending_q   <= pending_d;
            eating_q    <= eating_d;
            fork_busy_q <= fork_busy_d;
            evt_out_q   <= evt_out_d;
            rr_ptr_q    <= rr_ptr_d;
            tick_q      <= tick_d;
        end
    end

    assign evt_out   = evt_out_q;
    assign eating    = eating_q;
    assign fork_busy = fork_busy_q;

endmodule

// File: tb/tb_fork_arbiter.sv
// Directed testbench for fork_arbiter: three instances cover N=3/TICK=16,
// N=5/TICK=16 and N=3/TICK=4 configurations.
module tb_fork_arbiter;

    logic        clk;
    logic        reset;

    logic [2:0]  hungry_a, done_a, eating_a, busy_a;
    logic [5:0]  evt_a;
    logic [4:0]  hungry_b, done_b, eating_b, busy_b;
    logic [9:0]  evt_b;
    logic [2:0]  hungry_c, done_c, eating_c, busy_c;
    logic [5:0]  evt_c;

    int checks;
    int errors;

    fork_arbiter #(.N_PHILO(3), .EVENT_W(2), .TICK_DIV(16)) dut_a (
        .clk(clk), .reset(reset), .hungry(hungry_a), .done(done_a),
        .evt_out(evt_a), .eating(eating_a), .fork_busy(busy_a)
    );

    fork_arbiter #(.N_PHILO(5), .EVENT_W(2), .TICK_DIV(16)) dut_b (
        .clk(clk), .reset(reset), .hungry(hungry_b), .done(done_b),
        .evt_out(evt_b), .eating(eating_b), .fork_busy(busy_b)
    );

    fork_arbiter #(.N_PHILO(3), .EVENT_W(2), .TICK_DIV(4)) dut_c (
        .clk(clk), .reset(reset), .hungry(hungry_c), .done(done_c),
        .evt_out(evt_c), .eating(eating_c), .fork_busy(busy_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One active edge, then settle 1 time unit so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        hungry_a = '0; done_a = '0;
        hungry_b = '0; done_b = '0;
        hungry_c = '0; done_c = '0;
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] exp_evt;
        do_reset();
        checks++;
        if ({evt_a, eating_a, busy_a} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL reset_a: got evt=%b eat=%b busy=%b expected all 0", evt_a, eating_a, busy_a);
        end
        checks++;
        if ({evt_b, eating_b, busy_b} !== 20'h00000) begin
            errors++;
            $display("[TB] FAIL reset_b: got evt=%b eat=%b busy=%b expected all 0", evt_b, eating_b, busy_b);
        end
        checks++;
        if ({evt_c, eating_c, busy_c} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL reset_c: got evt=%b eat=%b busy=%b expected all 0", evt_c, eating_c, busy_c);
        end
        for (int c = 1; c <= 48; c++) begin
            step();
            exp_evt = (c % 16 == 0) ? 6'b101010 : 6'b000000;
            checks++;
            if (evt_a !== exp_evt || eating_a !== 3'b000 || busy_a !== 3'b000) begin
                errors++;
                $display("[TB] FAIL tick_cycle%0d: got evt=%b eat=%b busy=%b expected evt=%b eat=000 busy=000",
                         c, evt_a, eating_a, busy_a, exp_evt);
            end
        end
    endtask

    task automatic test_single_grant();
        do_reset();
        hungry_a = 3'b001;
        step();
        hungry_a = 3'b000;
        checks++;
        if (evt_a !== 6'b000000 || eating_a !== 3'b000) begin
            errors++;
            $display("[TB] FAIL single_latch: got evt=%b eat=%b expected evt=000000 eat=000", evt_a, eating_a);
        end
        step();
        checks++;
        if (evt_a !== 6'b000001 || eating_a !== 3'b001 || busy_a !== 3'b011) begin
            errors++;
            $display("[TB] FAIL single_eat: got evt=%b eat=%b busy=%b expected 000001 001 011", evt_a, eating_a, busy_a);
        end
        step();
        checks++;
        if (evt_a !== 6'b000000 || eating_a !== 3'b001 || busy_a !== 3'b011) begin
            errors++;
            $display("[TB] FAIL single_hold: got evt=%b eat=%b busy=%b expected 000000 001 011", evt_a, eating_a, busy_a);
        end
    endtask

    task automatic test_rr_release();
        do_reset();
        hungry_a = 3'b011;
        step();
        hungry_a = 3'b000;
        step();
        checks++;
        if (evt_a !== 6'b000001 || eating_a !== 3'b001 || busy_a !== 3'b011) begin
            errors++;
            $display("[TB] FAIL rr_first: got evt=%b eat=%b busy=%b expected 000001 001 011", evt_a, eating_a, busy_a);
        end
        step();
        checks++;
        if (evt_a !== 6'b000000 || eating_a !== 3'b001) begin
            errors++;
            $display("[TB] FAIL rr_blocked: got evt=%b eat=%b expected 000000 001", evt_a, eating_a);
        end
        done_a = 3'b001;
        step();
        done_a = 3'b000;
        checks++;
        if (evt_a !== 6'b000000 || eating_a !== 3'b000 || busy_a !== 3'b000) begin
            errors++;
            $display("[TB] FAIL rr_release: got evt=%b eat=%b busy=%b expected 000000 000 000", evt_a, eating_a, busy_a);
        end
        step();
        checks++;
        if (evt_a !== 6'b000100 || eating_a !== 3'b010 || busy_a !== 3'b110) begin
            errors++;
            $display("[TB] FAIL rr_second: got evt=%b eat=%b busy=%b expected 000100 010 110", evt_a, eating_a, busy_a);
        end
    endtask

    task automatic test_five();
        do_reset();
        hungry_b = 5'b11111;
        step();
        hungry_b = 5'b00000;
        step();
        checks++;
        if (evt_b !== 10'b0000000001 || eating_b !== 5'b00001 || busy_b !== 5'b00011) begin
            errors++;
            $display("[TB] FAIL five_g0: got evt=%b eat=%b busy=%b expected 0000000001 00001 00011", evt_b, eating_b, busy_b);
        end
        step();
        checks++;
        if (evt_b !== 10'b0000010000 || eating_b !== 5'b00101 || busy_b !== 5'b01111) begin
            errors++;
            $display("[TB] FAIL five_g2: got evt=%b eat=%b busy=%b expected 0000010000 00101 01111", evt_b, eating_b, busy_b);
        end
        step();
        checks++;
        if (evt_b !== 10'b0000000000 || eating_b !== 5'b00101 || busy_b !== 5'b01111) begin
            errors++;
            $display("[TB] FAIL five_none: got evt=%b eat=%b busy=%b expected 0000000000 00101 01111", evt_b, eating_b, busy_b);
        end
        // Releasing philo0 lets pending philo4 (not philo1, whose fork 2 is held) eat next.
        done_b = 5'b00001;
        step();
        done_b = 5'b00000;
        checks++;
        if (evt_b !== 10'b0000000000 || eating_b !== 5'b00100 || busy_b !== 5'b01100) begin
            errors++;
            $display("[TB] FAIL five_release: got evt=%b eat=%b busy=%b expected 0000000000 00100 01100", evt_b, eating_b, busy_b);
        end
        step();
        checks++;
        if (evt_b !== 10'b0100000000 || eating_b !== 5'b10100 || busy_b !== 5'b11101) begin
            errors++;
            $display("[TB] FAIL five_g4: got evt=%b eat=%b busy=%b expected 0100000000 10100 11101", evt_b, eating_b, busy_b);
        end
    endtask

    task automatic test_tick_collision();
        do_reset();
        step();
        step();
        hungry_c = 3'b010;
        step();
        hungry_c = 3'b000;
        checks++;
        if (evt_c !== 6'b000000) begin
            errors++;
            $display("[TB] FAIL collide_pre: got evt=%b expected 000000", evt_c);
        end
        step();
        checks++;
        if (evt_c !== 6'b100110 || eating_c !== 3'b010 || busy_c !== 3'b110) begin
            errors++;
            $display("[TB] FAIL collide_tick: got evt=%b eat=%b busy=%b expected 100110 010 110", evt_c, eating_c, busy_c);
        end
        step();
        checks++;
        if (evt_c !== 6'b000000) begin
            errors++;
            $display("[TB] FAIL collide_after: got evt=%b expected 000000", evt_c);
        end
    endtask

    task automatic test_reset_mid_eat();
        do_reset();
        hungry_a = 3'b001;
        step();
        hungry_a = 3'b000;
        step();
        checks++;
        if (eating_a !== 3'b001) begin
            errors++;
            $display("[TB] FAIL mid_eat_setup: got eat=%b expected 001", eating_a);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({evt_a, eating_a, busy_a} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL mid_eat_reset: got evt=%b eat=%b busy=%b expected all 0", evt_a, eating_a, busy_a);
        end
        done_a = 3'b001;
        step();
        done_a = 3'b000;
        checks++;
        if ({evt_a, eating_a, busy_a} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL mid_eat_done: got evt=%b eat=%b busy=%b expected all 0", evt_a, eating_a, busy_a);
        end
        step();
        checks++;
        if ({evt_a, eating_a, busy_a} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL mid_eat_quiet: got evt=%b eat=%b busy=%b expected all 0", evt_a, eating_a, busy_a);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        hungry_a = 3'b001;
        step();
        step();
        hungry_a = 3'b000;
        checks++;
        if (evt_a !== 6'b000001 || eating_a !== 3'b001) begin
            errors++;
            $display("[TB] FAIL dup_eat: got evt=%b eat=%b expected 000001 001", evt_a, eating_a);
        end
        step();
        checks++;
        if (evt_a !== 6'b000000 || eating_a !== 3'b001) begin
            errors++;
            $display("[TB] FAIL dup_no_regrant: got evt=%b eat=%b expected 000000 001", evt_a, eating_a);
        end
        hungry_a = 3'b001;
        done_a   = 3'b001;
        step();
        hungry_a = 3'b000;
        done_a   = 3'b000;
        checks++;
        if (eating_a !== 3'b000 || busy_a !== 3'b000) begin
            errors++;
            $display("[TB] FAIL same_edge_done: got eat=%b busy=%b expected 000 000", eating_a, busy_a);
        end
        step();
        checks++;
        if (evt_a !== 6'b000000 || eating_a !== 3'b000) begin
            errors++;
            $display("[TB] FAIL same_edge_hungry_ignored: got evt=%b eat=%b expected 000000 000", evt_a, eating_a);
        end
        done_a = 3'b010;
        step();
        done_a = 3'b000;
        checks++;
        if ({evt_a, eating_a, busy_a} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL stray_done: got evt=%b eat=%b busy=%b expected all 0", evt_a, eating_a, busy_a);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        hungry_a = '0; done_a = '0;
        hungry_b = '0; done_b = '0;
        hungry_c = '0; done_c = '0;
        test_reset();
        test_single_grant();
        test_rr_release();
        test_five();
        test_tick_collision();
        test_reset_mid_eat();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fork_arbiter.md
Name: fork_arbiter

Overview:
- Upstream event source for the dining-philosopher array inside dining_table.
- Owns the N_PHILO forks and accepts hungry/done pulses from the philosophers.
- Grants forks with round-robin fairness and drives each philosopher's event_in with EAT and periodic TIMEOUT events.
- Philosopher i needs fork i and fork (i+1) mod N_PHILO.

Parameters:
- N_PHILO, 3, number of philosophers and forks (>=2).
- EVENT_W, 2, event code width; equals `EVENT_SIZE.
- TICK_DIV, 16, clk cycles per TIMEOUT broadcast (>=2).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high.
- hungry  input  N_PHILO  one-cycle request pulse per philosopher.
- done  input  N_PHILO  one-cycle finished-eating pulse per philosopher.
- evt_out  output  N_PHILO*EVENT_W  registered event to philosopher i in bits [i*EVENT_W +: EVENT_W].
- eating  output  N_PHILO  registered; philosopher i currently holds both forks.
- fork_busy  output  N_PHILO  registered; fork i is owned.

Behaviour:
- Event codes: 0 NONE, 1 EAT, 2 TIMEOUT; 3 is never driven.
- Reset (sampled high on an edge): pending, eating, fork_busy = 0; evt_out all NONE; rr_ptr = 0; tick counter = 0. Reset in the middle of an eat drops all ownership; no event is emitted for the dropped ownership.
- Request latch: hungry[i] sets pending[i] at the edge unless pending[i] or eating[i] is already 1. A duplicate hungry is ignored.
- Release: done[i] with eating[i]=1 clears eating[i], fork_busy[i] and fork_busy[(i+1)%N] at that edge. A done while not eating is ignored.
- Grant evaluation uses registered state only:
  - A fork freed at edge k is grantable from edge k+1.
  - A hungry sampled at edge k is grantable from edge k+1.
- Grant rule: at most one grant per edge.
  - Scan philosophers in order rr_ptr, rr_ptr+1, ... mod N.
  - Choose the first philosopher i with pending[i]=1 and both of its forks free.
  - On a grant: pending[i] to 0, eating[i] to 1, both forks busy, evt_out[i] = EAT for exactly one cycle, rr_ptr to (i+1) mod N.
  - With no candidate, rr_ptr holds.
- Latency: hungry at edge k with forks free gives EAT visible after edge k+1 (2 edges), with eating and fork_busy updating in the same cycle.
- Same-edge hungry[i] and done[i] while eating[i]=1: done is processed and hungry is ignored.
- Tick counter: counts 0..TICK_DIV-1 and wraps; width $clog2(TICK_DIV).
  - On the edge where the counter equals TICK_DIV-1, every evt_out lane is TIMEOUT for one cycle.
  - A lane receiving EAT on that same edge shows EAT; its TIMEOUT is dropped, not deferred.
- evt_out returns to NONE on every cycle without an event. Events are never held.

Test Plan:
1. Release reset, no requests, TICK_DIV=16 -> evt_out, eating and fork_busy stay 0 for 15 cycles; all lanes show TIMEOUT on cycle 16 after reset, and again every 16 cycles.
2. N=3, hungry=3'b001 at edge k -> evt_out lane0 = EAT after edge k+1 for one cycle only; eating=001 and fork_busy=011 from then on.
3. N=3, hungry=3'b011 at one edge -> philo0 granted (rr_ptr 0) and philo1 stays pending. Then done[0] at edge m -> fork_busy=000 after edge m; philo1 gets EAT after edge m+1, with eating=010 and fork_busy=110.
4. N=5, hungry=5'b11111 at one edge -> grants on successive edges: philo0, then philo2, then none. Result eating=00101, fork_busy=01111, pending=11010.
5. TICK_DIV=4, grant to philo1 timed to land on the tick edge -> lane1 = EAT; lanes 0 and 2 = TIMEOUT; the next cycle is all NONE.
6. Philo0 eating, assert reset for one edge, then pulse done[0] -> all outputs 0 after the reset edge; done ignored, with no change and no event.
